// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Multiply/divide op encodings, sequencer state encodings and
//               default latencies shared by the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int c_mul_lat_def = 32;
    localparam int c_div_lat_def = 32;
    localparam int c_cnt_w_def   = 6;

    localparam logic [2:0] c_md_none  = 3'b000;
    localparam logic [2:0] c_md_mult  = 3'b001;
    localparam logic [2:0] c_md_multu = 3'b010;
    localparam logic [2:0] c_md_div   = 3'b011;
    localparam logic [2:0] c_md_divu  = 3'b100;
    localparam logic [2:0] c_md_mthi  = 3'b101;
    localparam logic [2:0] c_md_mtlo  = 3'b110;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic logic md_op_valid(input logic [2:0] op);
        return (op != c_md_none) && (op <= c_md_mtlo);
    endfunction

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= c_md_mult) && (op <= c_md_divu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One-bit-per-step shift-add multiplier / restoring divider on
//               operand magnitudes; signs are restored on the 32nd step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_is_div,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_step,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mcand;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [4:0]  r_cnt;
    logic        r_active;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_hi_n;
    logic [31:0] w_lo_n;
    logic [63:0] w_prod_neg;
    logic [31:0] w_hi_f;
    logic [31:0] w_lo_f;
    logic        w_last;

    assign w_a_mag = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;

    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 33'd0);
        w_shift = {r_hi, r_lo[31]};
        w_ge    = (w_shift >= {1'b0, r_mcand});
        // The partial remainder after a successful subtract is below the divisor.
        w_sub   = w_shift[31:0] - r_mcand;
        if (r_is_div) begin
            w_hi_n = w_ge ? w_sub : w_shift[31:0];
            w_lo_n = {r_lo[30:0], w_ge};
        end else begin
            w_hi_n = w_sum[32:1];
            w_lo_n = {w_sum[0], r_lo[31:1]};
        end
        w_last     = (r_cnt == 5'd31);
        w_prod_neg = ~{w_hi_n, w_lo_n} + 64'd1;
        w_hi_f     = w_hi_n;
        w_lo_f     = w_lo_n;
        if (w_last) begin
            if (r_is_div) begin
                w_lo_f = r_neg_q ? (~w_lo_n + 32'd1) : w_lo_n;
                w_hi_f = r_neg_r ? (~w_hi_n + 32'd1) : w_hi_n;
            end else if (r_neg_q) begin
                w_hi_f = w_prod_neg[63:32];
                w_lo_f = w_prod_neg[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_mcand  <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= 5'd0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_hi     <= 32'd0;
            r_lo     <= w_a_mag;
            r_mcand  <= w_b_mag;
            r_is_div <= i_is_div;
            r_neg_q  <= i_signed && (i_a[31] ^ i_b[31]);
            r_neg_r  <= i_signed && i_a[31];
            r_cnt    <= 5'd0;
            r_active <= 1'b1;
        end else if (i_step && r_active) begin
            // Steps beyond the 32nd are ignored so longer latencies hold the result.
            r_hi  <= w_hi_f;
            r_lo  <= w_lo_f;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Sequencer for the iterative mul/div unit, HI/LO registers and
//               the stall requests that protect them in the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import cpu_defs::*;
#(
    parameter int MUL_LAT = c_mul_lat_def,
    parameter int DIV_LAT = c_div_lat_def,
    parameter int CNT_W   = c_cnt_w_def
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MDop,
    input  logic [31:0] EXE_A,
    input  logic [31:0] EXE_B,
    input  logic        EXE_adv,
    input  logic        EXE_flush,
    input  logic        ID_ReadHiLo,
    output logic        ID_shouldstall_md,
    output logic        EXE_shouldstall_md,
    output logic        MD_busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // The datapath produces one result bit per step; exact results need LAT >= 32.
    localparam logic [CNT_W-1:0] c_mul_init = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_init = CNT_W'(DIV_LAT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dz;
    logic [31:0]      r_dz_a;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_op_valid;
    logic        w_is_arith;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_signed;
    logic        w_div_zero;
    logic        w_issue;
    logic        w_start;
    logic        w_step;
    logic        w_busy;
    logic [31:0] w_iter_hi;
    logic [31:0] w_iter_lo;

    assign w_op_valid  = md_op_valid(EXE_MDop);
    assign w_is_arith  = md_is_arith(EXE_MDop);
    assign w_is_mul    = (EXE_MDop == c_md_mult) || (EXE_MDop == c_md_multu);
    assign w_is_div    = (EXE_MDop == c_md_div)  || (EXE_MDop == c_md_divu);
    assign w_is_signed = (EXE_MDop == c_md_mult) || (EXE_MDop == c_md_div);
    assign w_div_zero  = w_is_div && (EXE_B == 32'd0);
    assign w_issue     = w_op_valid && EXE_adv && !EXE_flush && (r_state == c_st_idle);
    assign w_start     = w_issue && w_is_arith;
    assign w_step      = (r_state == c_st_run);

    muldiv_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_is_div (w_is_div),
        .i_signed (w_is_signed),
        .i_a      (EXE_A),
        .i_b      (EXE_B),
        .i_step   (w_step),
        .o_hi     (w_iter_hi),
        .o_lo     (w_iter_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_next = w_div_zero ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (r_cnt == '0) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy             = (r_state != c_st_idle);
        MD_busy            = w_busy;
        ID_shouldstall_md  = ID_ReadHiLo && (w_busy || (w_op_valid && !EXE_flush));
        EXE_shouldstall_md = w_op_valid && !EXE_flush && w_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= w_is_mul ? c_mul_init : c_div_init;
        end else if (w_step && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Divide-by-zero bypasses the datapath; its result is fixed by the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dz   <= 1'b0;
            r_dz_a <= 32'd0;
        end else if (w_start) begin
            r_dz   <= w_div_zero;
            r_dz_a <= EXE_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == c_st_done) begin
            r_hi <= r_dz ? r_dz_a : w_iter_hi;
            r_lo <= r_dz ? 32'hFFFF_FFFF : w_iter_lo;
        end else if (w_issue && (EXE_MDop == c_md_mthi)) begin
            r_hi <= EXE_A;
        end else if (w_issue && (EXE_MDop == c_md_mtlo)) begin
            r_lo <= EXE_A;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed and random checks of the HI/LO sequencer against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 32;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  EXE_MDop;
    logic [31:0] EXE_A;
    logic [31:0] EXE_B;
    logic        EXE_adv;
    logic        EXE_flush;
    logic        ID_ReadHiLo;
    logic        ID_shouldstall_md;
    logic        EXE_shouldstall_md;
    logic        MD_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk                (clk),
        .rst                (rst),
        .EXE_MDop           (EXE_MDop),
        .EXE_A              (EXE_A),
        .EXE_B              (EXE_B),
        .EXE_adv            (EXE_adv),
        .EXE_flush          (EXE_flush),
        .ID_ReadHiLo        (ID_ReadHiLo),
        .ID_shouldstall_md  (ID_shouldstall_md),
        .EXE_shouldstall_md (EXE_shouldstall_md),
        .MD_busy            (MD_busy),
        .HI                 (HI),
        .LO                 (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {HI,LO} after the op, from plain arithmetic on the operands.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint sa, sb;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd1 || op == 3'd2) return MUL_LAT + 1;
        if (op == 3'd3 || op == 3'd4) return (b == 32'd0) ? 1 : DIV_LAT + 1;
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        EXE_MDop = op; EXE_A = a; EXE_B = b; EXE_adv = 1'b1; EXE_flush = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exe();
        EXE_MDop = 3'd0; EXE_adv = 1'b0; EXE_flush = 1'b0;
        EXE_A = $urandom; EXE_B = $urandom;
    endtask

    // Counts busy cycles after an issue edge, then checks HI/LO.
    task automatic wait_done(input int eb, input logic [63:0] er, input bit rd_id,
                             input bit flush_probe);
        int busy = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!MD_busy) break;
            busy++;
            if (rd_id) chk("id_stall_busy", 32'(ID_shouldstall_md), 32'd1);
            if (flush_probe && busy == 1) begin
                EXE_MDop = 3'd1; EXE_flush = 1'b1; EXE_adv = 1'b1;
                #1;
                chk("exe_stall_flush_busy", 32'(EXE_shouldstall_md), 32'd0);
                chk("id_stall_flush_busy", 32'(ID_shouldstall_md), 32'd0);
                clear_exe();
            end
        end
        chk("busy_cycles", 32'(busy), 32'(eb));
        if (rd_id) begin
            chk("id_stall_after", 32'(ID_shouldstall_md), 32'd0);
            ID_ReadHiLo = 1'b0;
        end
        m_hi = er[63:32];
        m_lo = er[31:0];
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit rd_id, input bit flush_probe);
        logic [63:0] er;
        er = ref_result(op, a, b, m_hi, m_lo);
        issue(op, a, b);
        clear_exe();
        if (rd_id) ID_ReadHiLo = 1'b1;
        wait_done(exp_busy(op, b), er, rd_id, flush_probe);
    endtask

    initial begin
        logic [63:0] er1, er2;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          held_busy;

        rst = 1'b1; EXE_MDop = 3'd0; EXE_A = 32'd0; EXE_B = 32'd0;
        EXE_adv = 1'b0; EXE_flush = 1'b0; ID_ReadHiLo = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(MD_busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_id_stall", 32'(ID_shouldstall_md), 32'd0);
        chk("rst_exe_stall", 32'(EXE_shouldstall_md), 32'd0);

        do_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        do_op(3'd4, 32'd100, 32'd7, 1'b1, 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        do_op(3'd6, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Second mult waits in EXE for the whole first op, then issues from IDLE.
        er1 = ref_result(3'd1, 32'd12345, 32'hFFFF_0000, m_hi, m_lo);
        er2 = ref_result(3'd1, 32'h7FFF_FFFF, 32'd3, er1[63:32], er1[31:0]);
        issue(3'd1, 32'd12345, 32'hFFFF_0000);
        EXE_A = 32'h7FFF_FFFF; EXE_B = 32'd3;
        held_busy = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!MD_busy) break;
            held_busy++;
            if (held_busy == 1 || held_busy == 20 || held_busy == MUL_LAT + 1)
                chk("exe_stall_held", 32'(EXE_shouldstall_md), 32'd1);
        end
        chk("held_busy_cycles", 32'(held_busy), 32'(MUL_LAT + 1));
        chk("exe_stall_idle", 32'(EXE_shouldstall_md), 32'd0);
        m_hi = er1[63:32]; m_lo = er1[31:0];
        chk("held_first_hi", HI, m_hi);
        chk("held_first_lo", LO, m_lo);
        @(posedge clk);
        #1 clear_exe();
        wait_done(MUL_LAT + 1, er2, 1'b0, 1'b0);

        // Held (no advance) and flushed ops while idle must not issue.
        @(negedge clk);
        EXE_MDop = 3'd1; EXE_A = 32'd9; EXE_B = 32'd9; EXE_adv = 1'b0; ID_ReadHiLo = 1'b1;
        #1;
        chk("id_stall_exe_op", 32'(ID_shouldstall_md), 32'd1);
        chk("exe_stall_idle_op", 32'(EXE_shouldstall_md), 32'd0);
        @(negedge clk);
        chk("held_no_issue", 32'(MD_busy), 32'd0);
        EXE_adv = 1'b1; EXE_flush = 1'b1;
        #1;
        chk("id_stall_flushed", 32'(ID_shouldstall_md), 32'd0);
        @(negedge clk);
        chk("flush_no_issue", 32'(MD_busy), 32'd0);
        chk("flush_hi_kept", HI, m_hi);
        chk("flush_lo_kept", LO, m_lo);
        clear_exe();
        ID_ReadHiLo = 1'b0;

        // Reset in the middle of RUN drops the op and clears HI/LO.
        issue(3'd1, 32'd77, 32'd88);
        clear_exe();
        repeat (10) @(negedge clk);
        chk("mid_run_busy", 32'(MD_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ID_ReadHiLo = 1'b1;
        @(negedge clk);
        chk("rst_run_busy", 32'(MD_busy), 32'd0);
        chk("rst_run_hi", HI, 32'd0);
        chk("rst_run_lo", LO, 32'd0);
        chk("rst_run_id_stall", 32'(ID_shouldstall_md), 32'd0);
        chk("rst_run_exe_stall", 32'(EXE_shouldstall_md), 32'd0);
        ID_ReadHiLo = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        chk("rst_run_stays_idle", 32'(MD_busy), 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, 1'(i % 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
